// File: rtl/ld_down_counter.sv
// Loadable binary down counter with an active-high borrow chain and a registered terminal-count pulse.
// Define LD_DOWN_COUNTER_AUTORELOAD_EN to make an underflow reload from the last loaded value instead of wrapping.
module ld_down_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter logic [31:0] RESET_VAL = '0
) (
   input  logic             CK,
   input  logic             CDN,
   input  logic             SP,
   input  logic             SD,
   input  logic [WIDTH-1:0] D,
   input  logic             BI,
   output logic [WIDTH-1:0] Q,
   output logic             BO,
   output logic             TC
);

   localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   logic             zero;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] rld_q, rld_d;
`endif

   assign zero = (q_q == '0);
   assign BO   = BI & zero;
   assign Q    = q_q;
   assign TC   = tc_q;

   // Every legal {SP,SD,BI} pattern is listed so that an unknown control falls to the X default.
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
      rld_d = rld_q;
`endif
      case ({SP, SD, BI})
         3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
            q_d  = q_q;
            tc_d = 1'b0;
         end
         3'b110, 3'b111: begin
            q_d = D;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
            rld_d = D;
`endif
         end
         3'b101: begin
            q_d  = q_q - WIDTH'(1);
            tc_d = zero;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
            if (zero) q_d = rld_q;
`endif
         end
         default: begin
            q_d  = 'x;
            tc_d = 1'bx;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
            rld_d = 'x;
`endif
         end
      endcase
   end

   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         q_q  <= RST_Q;
         tc_q <= 1'b0;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
         rld_q <= RST_Q;
`endif
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
         rld_q <= rld_d;
`endif
      end
   end

endmodule

// File: tb/tb_ld_down_counter.sv
// Directed bench for ld_down_counter: reset, load/countdown, priority, enable gating, async reset and a two-stage cascade.
module tb_ld_down_counter;

`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       ck, cdn;
   logic       sp, sd, bi;
   logic [3:0] d, q;
   logic       bo, tc;

   logic       c_sp, c_sd;
   logic [3:0] d_lo, d_hi, q_lo, q_hi;
   logic       bo_lo, bo_hi, tc_lo, tc_hi;

   int n_chk  = 0;
   int n_pass = 0;

   ld_down_counter #(.WIDTH(4), .RESET_VAL(32'h0)) dut (
      .CK(ck), .CDN(cdn), .SP(sp), .SD(sd), .D(d), .BI(bi), .Q(q), .BO(bo), .TC(tc)
   );

   ld_down_counter #(.WIDTH(4), .RESET_VAL(32'h0)) u_lo (
      .CK(ck), .CDN(cdn), .SP(c_sp), .SD(c_sd), .D(d_lo), .BI(1'b1), .Q(q_lo), .BO(bo_lo), .TC(tc_lo)
   );

   ld_down_counter #(.WIDTH(4), .RESET_VAL(32'h0)) u_hi (
      .CK(ck), .CDN(cdn), .SP(c_sp), .SD(c_sd), .D(d_hi), .BI(bo_lo), .Q(q_hi), .BO(bo_hi), .TC(tc_hi)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   logic [3:0] exp_q [5];
   logic       exp_tc[5];
   logic       exp_bo[5];

   initial begin
      cdn = 1'b0; sp = 1'b0; sd = 1'b0; bi = 1'b0; d = 4'h0;
      c_sp = 1'b0; c_sd = 1'b0; d_lo = 4'h0; d_hi = 4'h0;
      #1;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_tc", 32'(tc), 32'h0);
      tick();
      cdn = 1'b1;

      // 1: reset mid-count, then first decrement underflows
      sp = 1'b1; sd = 1'b1; d = 4'h9;
      tick();
      chk("t1_load9", 32'(q), 32'h9);
      sd = 1'b0; bi = 1'b1;
      #2 cdn = 1'b0;
      #1;
      chk("t1_async_q", 32'(q), 32'h0);
      chk("t1_async_tc", 32'(tc), 32'h0);
      cdn = 1'b1;
      tick();
      chk("t1_e1_q", 32'(q), AR ? 32'h0 : 32'hF);
      chk("t1_e1_tc", 32'(tc), 32'h1);
      tick();
      chk("t1_e2_q", 32'(q), AR ? 32'h0 : 32'hE);
      chk("t1_e2_tc", 32'(tc), AR ? 32'h1 : 32'h0);

      // 2: load 3 and count down through zero
      sd = 1'b1; d = 4'h3; bi = 1'b1;
      tick();
      chk("t2_load_q", 32'(q), 32'h3);
      chk("t2_load_tc", 32'(tc), 32'h0);
      sd = 1'b0;
      #1;
      chk("t2_bo_pre", 32'(bo), 32'h0);
      exp_q  = '{4'h2, 4'h1, 4'h0, AR ? 4'h3 : 4'hF, AR ? 4'h2 : 4'hE};
      exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_bo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t2_q%0d", i), 32'(q), 32'(exp_q[i]));
         chk($sformatf("t2_tc%0d", i), 32'(tc), 32'(exp_tc[i]));
         chk($sformatf("t2_bo%0d", i), 32'(bo), 32'(exp_bo[i]));
      end

      // 3: load beats decrement at zero
      sd = 1'b1; d = 4'h0;
      tick();
      chk("t3_zero", 32'(q), 32'h0);
      d = 4'hA; bi = 1'b1;
      #1;
      chk("t3_bo_pre", 32'(bo), 32'h1);
      tick();
      chk("t3_q", 32'(q), 32'hA);
      chk("t3_tc", 32'(tc), 32'h0);

      // 4: enable gating at zero; BO still follows BI
      d = 4'h0;
      tick();
      sp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sd = i[0];
         bi = (i != 1);
         d  = 4'h5;
         #1;
         chk($sformatf("t4_bo%0d", i), 32'(bo), (i != 1) ? 32'h1 : 32'h0);
         tick();
         chk($sformatf("t4_q%0d", i), 32'(q), 32'h0);
         chk($sformatf("t4_tc%0d", i), 32'(tc), 32'h0);
      end
      sp = 1'b1; sd = 1'b0; bi = 1'b0;
      #1;
      chk("t4_bi0_bo", 32'(bo), 32'h0);
      tick();
      chk("t4_bi0_q", 32'(q), 32'h0);
      chk("t4_bi0_tc", 32'(tc), 32'h0);

      // 6: reset during a load cycle; reload register also cleared
      sd = 1'b1; d = 4'h5;
      tick();
      chk("t6_load5", 32'(q), 32'h5);
      d = 4'h7;
      #2 cdn = 1'b0;
      tick();
      chk("t6_rst_q", 32'(q), 32'h0);
      chk("t6_rst_tc", 32'(tc), 32'h0);
      cdn = 1'b1; sd = 1'b0; bi = 1'b1;
      tick();
      chk("t6_uf_q", 32'(q), AR ? 32'h0 : 32'hF);
      chk("t6_uf_tc", 32'(tc), 32'h1);

      // 5: two-stage cascade forming an 8-bit down counter
      sp = 1'b0;
      c_sp = 1'b1; c_sd = 1'b1; d_lo = 4'h1; d_hi = 4'h0;
      tick();
      chk("t5_load", 32'({q_hi, q_lo}), 32'h01);
      c_sd = 1'b0;
      tick();
      chk("t5_e1", 32'({q_hi, q_lo}), 32'h00);
      chk("t5_e1_tc", 32'({tc_hi, tc_lo}), 32'h0);
      chk("t5_bo_chain", 32'({bo_hi, bo_lo}), 32'h3);
      tick();
      chk("t5_e2", 32'({q_hi, q_lo}), AR ? 32'h01 : 32'hFF);
      chk("t5_e2_tc", 32'({tc_hi, tc_lo}), 32'h3);
      tick();
      chk("t5_e3", 32'({q_hi, q_lo}), AR ? 32'h00 : 32'hFE);
      chk("t5_e3_tc", 32'({tc_hi, tc_lo}), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
